// File: rtl/ghr_spec_ckpt.sv
// Speculative global history register with per-branch checkpoints.
// IF shifts predictions in, EX rewinds on mispredict, WB retires into the committed copy.
module ghr_spec_ckpt #(
    parameter  int unsigned GHR_WIDTH  = 8,
    parameter  int unsigned CKPT_DEPTH = 4,
    localparam int unsigned TAG_W      = $clog2(CKPT_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spec_valid,
    input  logic                 i_spec_taken,
    output logic                 o_spec_ready,
    output logic [TAG_W-1:0]     o_spec_tag,
    input  logic                 i_resolve_valid,
    input  logic [TAG_W-1:0]     i_resolve_tag,
    input  logic                 i_resolve_mispred,
    input  logic                 i_resolve_taken,
    input  logic                 i_commit_valid,
    input  logic                 i_commit_taken,
    input  logic                 i_flush,
    output logic [GHR_WIDTH-1:0] o_ghr,
    output logic [GHR_WIDTH-1:0] o_ghr_commit,
    output logic [TAG_W:0]       o_count,
    output logic                 o_empty
);

    logic [GHR_WIDTH-1:0] ckpt_q [CKPT_DEPTH];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [GHR_WIDTH-1:0] ghr_commit_q, ghr_commit_d;
    logic [TAG_W-1:0]     head_q, head_d;
    logic [TAG_W-1:0]     tail_q, tail_d;
    logic [TAG_W:0]       count_q, count_d;
    logic [TAG_W:0]       dec;
    logic [TAG_W-1:0]     res_off;
    logic                 full, commit_fire, alloc, mispred, ckpt_we;

    always_comb begin
        full         = (count_q == (TAG_W+1)'(CKPT_DEPTH));
        commit_fire  = i_commit_valid && (count_q != '0);
        alloc        = i_spec_valid && !full;
        mispred      = i_resolve_valid && i_resolve_mispred;
        dec          = (TAG_W+1)'(commit_fire);
        res_off      = i_resolve_tag - head_q;
        head_d       = head_q + TAG_W'(commit_fire);
        ghr_commit_d = commit_fire ? {ghr_commit_q[GHR_WIDTH-2:0], i_commit_taken} : ghr_commit_q;

        ghr_d   = ghr_q;
        tail_d  = tail_q;
        count_d = count_q - dec;
        ckpt_we = 1'b0;
        // Retirement runs alongside whichever of flush/rewind/allocate wins.
        if (i_flush) begin
            ghr_d   = ghr_commit_d;
            tail_d  = head_d;
            count_d = '0;
        end else if (mispred) begin
            ghr_d   = {ckpt_q[i_resolve_tag][GHR_WIDTH-2:0], i_resolve_taken};
            tail_d  = i_resolve_tag + 1'b1;
            count_d = {1'b0, res_off} + (TAG_W+1)'(1) - dec;
        end else if (alloc) begin
            ckpt_we = 1'b1;
            ghr_d   = {ghr_q[GHR_WIDTH-2:0], i_spec_taken};
            tail_d  = tail_q + 1'b1;
            count_d = count_q + (TAG_W+1)'(1) - dec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ghr_q        <= '0;
            ghr_commit_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            ghr_q        <= ghr_d;
            ghr_commit_q <= ghr_commit_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Snapshots are never cleared; validity is defined by head/count alone.
    always_ff @(posedge i_clk) begin
        if (ckpt_we) begin
            ckpt_q[tail_q] <= ghr_q;
        end
    end

    assign o_ghr        = ghr_q;
    assign o_ghr_commit = ghr_commit_q;
    assign o_count      = count_q;
    assign o_empty      = (count_q == '0);
    assign o_spec_ready = !full;
    assign o_spec_tag   = tail_q;

    a_resolve_tag_live: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_resolve_valid |-> ({1'b0, res_off} < count_q));

endmodule
